// File: rtl/input_manager_pkg.sv
// Shared types and default timing constants for the push-button input path.
package input_manager_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } key_rep_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF  = 1_000_000;
    localparam int unsigned DAS_FRAMES_DEF       = 16;
    localparam int unsigned ARR_FRAMES_DEF       = 6;
    localparam int unsigned SOFT_DROP_FRAMES_DEF = 3;

endpackage

// File: rtl/button_debounce.sv
// One push button: 2-flop synchroniser, consecutive-cycle debounce counter
// and rising-edge detect of the debounced level.
module button_debounce
    import input_manager_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int unsigned    CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_a  <= btn;
            sync_b  <= sync_a;
            level_q <= level;
            // Any cycle agreeing with the accepted level restarts the run.
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/input_manager.sv
// Turns the five raw buttons into single-cycle key pulses, with DAS/ARR
// repeat on left/right and a fixed soft-drop repeat on down.
module input_manager
    import input_manager_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned DAS_FRAMES       = DAS_FRAMES_DEF,
    parameter int unsigned ARR_FRAMES       = ARR_FRAMES_DEF,
    parameter int unsigned SOFT_DROP_FRAMES = SOFT_DROP_FRAMES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_game,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_down,
    input  logic btn_rotate,
    input  logic btn_drop,
    output logic key_left,
    output logic key_right,
    output logic key_down,
    output logic key_rotate,
    output logic key_drop
);

    localparam logic [7:0] DAS_L  = 8'(DAS_FRAMES);
    localparam logic [7:0] ARR_L  = 8'(ARR_FRAMES);
    localparam logic [7:0] SOFT_L = 8'(SOFT_DROP_FRAMES);

    // Index order: 0 left, 1 right, 2 down, 3 rotate, 4 drop.
    logic [4:0] btn_vec;
    logic [4:0] level;
    logic [4:0] press;
    logic [1:0] lr_pulse;
    logic       freeze;

    assign btn_vec = {btn_drop, btn_rotate, btn_down, btn_right, btn_left};

    for (genvar b = 0; b < 5; b++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_vec[b]),
            .level(level[b]),
            .press(press[b])
        );
    end

    assign freeze = level[0] & level[1];

    for (genvar i = 0; i < 2; i++) begin : g_lr
        key_rep_state_t state;
        key_rep_state_t state_nxt;
        logic [7:0]     cnt;
        logic [7:0]     cnt_nxt;
        logic [7:0]     cnt_inc;
        logic           pulse;

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            pulse     = 1'b0;
            cnt_inc   = cnt + 8'd1;
            if (!level[i]) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else if (press[i]) begin
                state_nxt = DELAY;
                cnt_nxt   = '0;
                pulse     = 1'b1;
            end else if (tick_game && !freeze) begin
                case (state)
                    DELAY: begin
                        if (cnt_inc == DAS_L) begin
                            state_nxt = REPEAT;
                            cnt_nxt   = '0;
                            pulse     = 1'b1;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                    REPEAT: begin
                        if (cnt_inc == ARR_L) begin
                            cnt_nxt = '0;
                            pulse   = 1'b1;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign lr_pulse[i] = pulse;
    end

    key_rep_state_t dn_state;
    key_rep_state_t dn_state_nxt;
    logic [7:0]     dn_cnt;
    logic [7:0]     dn_cnt_nxt;
    logic [7:0]     dn_cnt_inc;
    logic           dn_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            dn_state <= IDLE;
            dn_cnt   <= '0;
        end else begin
            dn_state <= dn_state_nxt;
            dn_cnt   <= dn_cnt_nxt;
        end
    end

    always_comb begin
        dn_state_nxt = dn_state;
        dn_cnt_nxt   = dn_cnt;
        dn_pulse     = 1'b0;
        dn_cnt_inc   = dn_cnt + 8'd1;
        if (!level[2]) begin
            dn_state_nxt = IDLE;
            dn_cnt_nxt   = '0;
        end else if (press[2]) begin
            dn_state_nxt = REPEAT;
            dn_cnt_nxt   = '0;
            dn_pulse     = 1'b1;
        end else if (tick_game && dn_state == REPEAT) begin
            if (dn_cnt_inc == SOFT_L) begin
                dn_cnt_nxt = '0;
                dn_pulse   = 1'b1;
            end else begin
                dn_cnt_nxt = dn_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_left   <= 1'b0;
            key_right  <= 1'b0;
            key_down   <= 1'b0;
            key_rotate <= 1'b0;
            key_drop   <= 1'b0;
        end else begin
            key_left   <= lr_pulse[0];
            key_right  <= lr_pulse[1];
            key_down   <= dn_pulse;
            key_rotate <= press[3] & level[3];
            key_drop   <= press[4] & level[4];
        end
    end

endmodule
